// File: rtl/fetch_mem_sequencer.sv
// Multi-cycle fetch/execute/memory/writeback sequencer sharing one memory port.
// Optional macro SEQ_TIMEOUT_EN adds a bus-wait watchdog that halts on an unanswered request.
module fetch_mem_sequencer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isLoad,
  input  logic        isStore,
  input  logic [31:0] pc,
  input  logic [31:0] aluOut,
  input  logic [31:0] memWdata,
  input  logic [3:0]  memWMask,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] memRdata,
  output logic        commit,
  output logic [31:0] retired,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_instr;
  logic [31:0] r_mem_rdata;
  logic [31:0] r_retired;

  logic w_in_fetch;
  logic w_in_mem;
  logic w_req;
  logic w_store;
  logic w_load_only;
  logic w_timeout;

  assign w_in_fetch  = (r_state == S_FETCH);
  assign w_in_mem    = (r_state == S_MEM);
  assign w_req       = w_in_fetch | w_in_mem;
  // A decode claiming both load and store is handled as a store.
  assign w_store     = isStore;
  assign w_load_only = isLoad & ~isStore;

  assign mem_req   = w_req;
  assign mem_addr  = w_in_fetch ? pc : (w_in_mem ? aluOut : 32'h0);
  assign mem_we    = w_in_mem & w_store;
  assign mem_wmask = (w_in_mem & w_store) ? memWMask : 4'h0;
  assign mem_wdata = w_in_mem ? memWdata : 32'h0;

  assign instr    = r_instr;
  assign memRdata = r_mem_rdata;
  assign retired  = r_retired;
  assign commit   = (r_state == S_WB);

`ifdef SEQ_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wait_cnt;
  logic          r_bus_err;

  // Fires on the last tolerated unanswered cycle; a ready in that cycle still completes.
  assign w_timeout = w_req & ~mem_ready & (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign bus_err   = r_bus_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      if (w_req & ~mem_ready & ~w_timeout) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                                 r_wait_cnt <= '0;
      if (w_timeout) r_bus_err <= 1'b1;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
  assign w_timeout    = 1'b0;
  assign bus_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_instr     <= 32'h0000_0013;
      r_mem_rdata <= 32'h0;
      r_retired   <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= S_FETCH;
        S_FETCH: begin
          if (w_timeout) begin
            r_state <= S_HALT;
          end else if (mem_ready) begin
            r_instr <= mem_rdata;
            r_state <= S_EXEC;
          end
        end
        S_EXEC:  r_state <= (isLoad | isStore) ? S_MEM : S_WB;
        S_MEM: begin
          if (w_timeout) begin
            r_state <= S_HALT;
          end else if (mem_ready) begin
            if (w_load_only) r_mem_rdata <= mem_rdata;
            r_state <= S_WB;
          end
        end
        S_WB: begin
          r_retired <= r_retired + 32'h1;
          r_state   <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
